// File: rtl/jtag_bus_dr_pkg.sv
// jtag_bus_dr_pkg: shared encodings for the JTAG bus data register.
// Frame opcodes, status bit positions inside the captured word, and
// the bus-side state enum.
package jtag_bus_dr_pkg;

  // Opcode carried in the top two bits of an update frame
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_SETADDR = 2'b01,
    OP_READ    = 2'b10,
    OP_WRITE   = 2'b11
  } op_e;

  // Bit positions inside the two-bit status field of the capture word
  localparam int ST_BUSY = 0;
  localparam int ST_ERR  = 1;

  // Bus-side state
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // READ and WRITE both start a bus cycle; the low opcode bit selects write
  function automatic logic op_is_access(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/jtag_bus_dr_timer.sv
// jtag_bus_dr_timer: watchdog for an unacknowledged bus request.
// Counts cycles while the request is up without an acknowledge and flags
// timeout on the cycle the request has been high for TIMEOUT_CYC cycles.
// An acknowledge on that same cycle suppresses the timeout.
module jtag_bus_dr_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  // Counter holds at most TIMEOUT_CYC-1 before the request is dropped
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: zero while idle so every new request starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (!req) begin
      cnt_d = '0;
    end else if (!ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = req & ~ack & (cnt_q == CNT_LAST);

endmodule

// File: rtl/jtag_bus_dr.sv
// jtag_bus_dr: JTAG user data register that turns scanned frames into
// single-beat REQ/ACK bus reads and writes, all in the TCK domain.
// Frame (LSB shifted first): [DATA_W-1:0] data, then ADDR_W address bits,
// then a two-bit opcode. Capture word: last read data, current address,
// then {ERR, BUSY}. The address register advances by ADDR_INC after every
// acknowledged access.
// Optional: define JTAG_BUS_DR_TIMEOUT_EN to abort requests that stay
// unacknowledged for TIMEOUT_CYC cycles (sets ERR, no address advance).
module jtag_bus_dr
  import jtag_bus_dr_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ADDR_INC    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              TCK,
  input  logic              RESET,
  input  logic              SEL,
  input  logic              CAPTURE,
  input  logic              SHIFT,
  input  logic              UPDATE,
  input  logic              TDI,
  output logic              TDO,
  output logic              REQ,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              ACK
);

  localparam int W = 2 + ADDR_W + DATA_W;

  logic [W-1:0]      sr_d,    sr_q;
  logic              req_d,   req_q;
  logic              we_d,    we_q;
  logic [ADDR_W-1:0] addr_d,  addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              err_d,   err_q;
  state_e            state_d, state_q;

  op_e               op_s;
  logic [ADDR_W-1:0] field_addr_s;
  logic [DATA_W-1:0] field_data_s;
  logic              upd_s;
  logic              cap_s;
  logic              done_s;
  logic              err_evt_s;
  logic              timeout_s;
  logic [1:0]        status_s;

  // Update decodes the frame as it stood before the Update-DR edge
  assign op_s         = op_e'(sr_q[W-1 -: 2]);
  assign field_addr_s = sr_q[DATA_W +: ADDR_W];
  assign field_data_s = sr_q[DATA_W-1:0];
  assign upd_s        = SEL & UPDATE;
  assign cap_s        = SEL & CAPTURE;
  assign done_s       = req_q & ACK;

`ifdef JTAG_BUS_DR_TIMEOUT_EN
  jtag_bus_dr_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (TCK),
    .rst    (RESET),
    .req    (req_q),
    .ack    (ACK),
    .timeout(timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Bus FSM: accept accesses in IDLE, finish on ACK (or timeout) in BUSY
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_evt_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (upd_s) begin
          case (op_s)
            OP_SETADDR: addr_d = field_addr_s;
            OP_READ, OP_WRITE: begin
              req_d   = 1'b1;
              we_d    = op_s[0];
              wdata_d = field_data_s;
              state_d = S_BUSY;
            end
            default: addr_d = addr_q;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // Any real command while an access is outstanding is dropped
        if (upd_s && (op_s != OP_NOP)) begin
          err_evt_s = 1'b1;
        end else begin
          err_evt_s = 1'b0;
        end
        if (done_s) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
          addr_d  = addr_q + ADDR_W'(ADDR_INC);
          if (!we_q) begin
            rdata_d = RDATA;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (timeout_s) begin
          req_d     = 1'b0;
          state_d   = S_IDLE;
          err_evt_s = 1'b1;
        end else begin
          state_d = S_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Status field of the capture word, BUSY mirrors the registered request
  always_comb begin
    status_s          = 2'b00;
    status_s[ST_BUSY] = req_q;
    status_s[ST_ERR]  = err_q;
  end

  // Shift register (capture beats shift) and read-to-clear error flag
  always_comb begin
    if (cap_s) begin
      sr_d = {status_s, addr_q, rdata_q};
    end else if (SEL && SHIFT) begin
      sr_d = {TDI, sr_q[W-1:1]};
    end else begin
      sr_d = sr_q;
    end
    if (err_evt_s) begin
      err_d = 1'b1;
    end else if (cap_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers, reset overrides any access in flight
  always_ff @(posedge TCK) begin
    if (RESET) begin
      sr_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      sr_q    <= sr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign TDO   = sr_q[0];
  assign REQ   = req_q;
  assign WE    = we_q;
  assign ADDR  = addr_q;
  assign WDATA = wdata_q;

endmodule

// File: tb/tb_jtag_bus_dr.sv
// tb_jtag_bus_dr: directed frames plus randomized TAP/bus activity,
// checked every cycle against a behavioural model of the data register.
// Follows JTAG_BUS_DR_TIMEOUT_EN to pick the matching expectations.
module tb_jtag_bus_dr;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int W   = 2 + AW + DW;
  localparam int INC = 4;
  localparam int TO  = 8;
`ifdef JTAG_BUS_DR_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic          TCK = 1'b0;
  logic          RESET = 1'b1;
  logic          SEL = 1'b0, CAPTURE = 1'b0, SHIFT = 1'b0, UPDATE = 1'b0, TDI = 1'b0;
  logic          ACK = 1'b0;
  logic [DW-1:0] RDATA = '0;
  logic          TDO, REQ, WE;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WDATA;

  always #5 TCK = ~TCK;

  jtag_bus_dr #(.ADDR_W(AW), .DATA_W(DW), .ADDR_INC(INC), .TIMEOUT_CYC(TO)) dut (
    .TCK(TCK), .RESET(RESET), .SEL(SEL), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
    .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .REQ(REQ), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents as plain values
  logic [W-1:0]  m_sr = '0;
  bit            m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  int            m_hi = 0;

  always @(posedge TCK) begin : model
    logic [W-1:0]  sr0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] rd0;
    logic [1:0]    op;
    bit            req0, err0, evt;
    if (RESET) begin
      m_sr = '0; m_req = 0; m_we = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_hi = 0;
    end else begin
      sr0 = m_sr; req0 = m_req; err0 = m_err; addr0 = m_addr; rd0 = m_rdata;
      evt = 0;
      op = sr0[W-1 -: 2];
      if (req0) begin
        if (ACK) begin
          m_req = 0;
          if (!m_we) m_rdata = RDATA;
          m_addr = addr0 + AW'(INC);
        end else begin
          m_hi++;
          if (TO_ON && m_hi >= TO) begin
            m_req = 0;
            evt = 1;
          end
        end
      end
      if (SEL && UPDATE && op != 2'd0) begin
        if (req0) evt = 1;
        else if (op == 2'd1) m_addr = sr0[DW +: AW];
        else begin
          m_req = 1; m_we = (op == 2'd3); m_wdata = sr0[DW-1:0]; m_hi = 0;
        end
      end
      if (SEL && CAPTURE) m_sr = {err0, req0, addr0, rd0};
      else if (SEL && SHIFT) m_sr = (sr0 >> 1) | (W'(TDI) << (W - 1));
      if (evt) m_err = 1;
      else if (SEL && CAPTURE) m_err = 0;
    end
  end

  // Compare DUT to model shortly after every active edge
  always @(posedge TCK) begin
    #1;
    chk("tdo", TDO, m_sr[0]);
    chk("req", REQ, m_req);
    if (m_req) begin
      chk("we", WE, m_we);
      chk("addr", ADDR, m_addr);
      chk("wdata", WDATA, m_wdata);
    end
  end

  // Bus responder: ACK after ack_dly idle cycles, optional stray ACKs
  bit            ack_en = 1'b1, spur_en = 1'b0, rd_fix = 1'b0;
  int            ack_dly = 0, wcnt = 0;
  logic [DW-1:0] rd_val = '0;

  initial begin
    forever begin
      @(negedge TCK);
      RDATA = rd_fix ? rd_val : DW'($urandom);
      if (REQ && ack_en) begin
        if (wcnt >= ack_dly) begin ACK = 1'b1; wcnt = 0; end
        else begin ACK = 1'b0; wcnt++; end
      end else begin
        ACK = (spur_en && !REQ) ? ($urandom_range(0, 3) == 0) : 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic cyc(input bit sel, input bit cap, input bit sh, input bit upd, input bit tdi);
    SEL = sel; CAPTURE = cap; SHIFT = sh; UPDATE = upd; TDI = tdi;
    @(negedge TCK);
  endtask

  // Capture, shift a whole frame in (collecting the capture word), update
  task automatic scan(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output logic [W-1:0] cap);
    logic [W-1:0] fr;
    fr  = {op, a, d};
    cap = '0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      cap[i] = TDO;
      cyc(1'b1, 1'b0, 1'b1, 1'b0, fr[i]);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    SEL = 1'b0; UPDATE = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (REQ && n < 200) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk({nm, " idle"}, REQ, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] cap;
    int n;
    repeat (3) @(negedge TCK);
    RESET = 1'b0;

    // Reset state: capture word all zero, no request
    scan(2'b00, '0, '0, cap);
    chk("reset capture", cap, '0);
    chk("reset req", REQ, 1'b0);

    // SETADDR then WRITE
    ack_dly = 3;
    scan(2'b01, 32'h0000_1000, '0, cap);
    scan(2'b11, 32'h0000_0000, 32'hDEAD_BEEF, cap);
    chk("wr req", REQ, 1'b1);
    chk("wr we", WE, 1'b1);
    chk("wr addr", ADDR, 32'h0000_1000);
    chk("wr wdata", WDATA, 32'hDEAD_BEEF);
    wait_idle("wr");
    scan(2'b00, '0, '0, cap);
    chk("wr cap addr", cap[DW +: AW], 32'h0000_1004);
    chk("wr cap status", cap[W-1 -: 2], 2'b00);

    // Two reads in a burst
    rd_fix = 1'b1; ack_dly = 1;
    rd_val = 32'hBEEF_0001;
    scan(2'b10, 32'h5555_5555, '0, cap);
    chk("rd1 addr", ADDR, 32'h0000_1004);
    chk("rd1 we", WE, 1'b0);
    wait_idle("rd1");
    rd_val = 32'hBEEF_0002;
    scan(2'b10, '0, '0, cap);
    chk("rd2 addr", ADDR, 32'h0000_1008);
    wait_idle("rd2");
    scan(2'b00, '0, '0, cap);
    chk("rd cap data", cap[DW-1:0], 32'hBEEF_0002);
    chk("rd cap addr", cap[DW +: AW], 32'h0000_100C);

    // Command while busy is rejected and flags ERR (read-to-clear)
    ack_en = 1'b0;
    scan(2'b11, '0, 32'h1111_2222, cap);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    SEL = 1'b0; UPDATE = 1'b0;
    chk("busy req held", REQ, 1'b1);
    chk("busy addr held", ADDR, 32'h0000_100C);
    scan(2'b00, '0, '0, cap);
    chk("busy err status", cap[W-1 -: 2], 2'b11);
    scan(2'b00, '0, '0, cap);
    chk("busy err cleared", cap[W-1 -: 2], TO_ON ? 2'b10 : 2'b01);
    ack_en = 1'b1;
    wait_idle("busy");

    // Address wrap
    ack_dly = 0;
    scan(2'b01, 32'hFFFF_FFFC, '0, cap);
    scan(2'b10, '0, '0, cap);
    chk("wrap addr", ADDR, 32'hFFFF_FFFC);
    wait_idle("wrap");
    scan(2'b00, '0, '0, cap);
    chk("wrap cap addr", cap[DW +: AW], 32'h0000_0000);

    // Unacknowledged request
    ack_en = 1'b0;
    scan(2'b01, 32'h0000_2000, '0, cap);
    scan(2'b11, '0, 32'hCAFE_F00D, cap);
`ifdef JTAG_BUS_DR_TIMEOUT_EN
    n = 0;
    while (REQ && n < 100) begin
      n++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("timeout req cycles", n, 8);
    scan(2'b00, '0, '0, cap);
    chk("timeout status", cap[W-1 -: 2], 2'b10);
    chk("timeout addr", cap[DW +: AW], 32'h0000_2000);
    // ACK on the timeout edge completes normally
    ack_en = 1'b1; ack_dly = TO - 1;
    scan(2'b10, '0, '0, cap);
    wait_idle("late ack");
    scan(2'b00, '0, '0, cap);
    chk("late ack addr", cap[DW +: AW], 32'h0000_2004);
    chk("late ack status", cap[W-1 -: 2], 2'b00);
`else
    n = 0;
    repeat (1000) begin
      if (REQ) n++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("no timeout req cycles", n, 1000);
    chk("no timeout req still", REQ, 1'b1);
    RESET = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset drops req", REQ, 1'b0);
    RESET = 1'b0;
`endif

    // Randomized TAP traffic, bus latency and occasional reset
    ack_en = 1'b1; spur_en = 1'b1; rd_fix = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) ack_dly = $urandom_range(0, 10);
      RESET = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
          1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom));
    end
    RESET = 1'b0; SEL = 1'b0; CAPTURE = 1'b0; SHIFT = 1'b0; UPDATE = 1'b0;
    repeat (2) @(negedge TCK);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_bus_dr.md
Name: jtag_bus_dr

Overview:
Parametrised JTAG user data register that turns scanned frames into single-beat bus reads and writes.
- Holds an address register that auto-increments after each access, so bursts need no address reshift.
- Captures status and read data for scan-out.
- Sits behind the BSCAN user-DR decode, entirely in the TCK domain, driving a simple REQ/ACK bus.

Parameters:
ADDR_W, 32, width of address register and ADDR port
DATA_W, 32, width of write/read data
ADDR_INC, 4, increment added to address after each completed access (modulo 2^ADDR_W)
TIMEOUT_CYC, 255, cycles before an unacknowledged request aborts (only with optional feature)

Ports:
TCK  in  1  sole clock, all logic on posedge
RESET  in  1  synchronous active-high reset
SEL  in  1  this DR selected by TAP IR decode
CAPTURE  in  1  TAP Capture-DR
SHIFT  in  1  TAP Shift-DR
UPDATE  in  1  TAP Update-DR
TDI  in  1  serial in
TDO  out  1  serial out, combinational SR[0]
REQ  out  1  bus request
WE  out  1  1=write, 0=read, valid while REQ
ADDR  out  ADDR_W  bus address, valid while REQ
WDATA  out  DATA_W  write data, valid while REQ
RDATA  in  DATA_W  read data, sampled on ACK
ACK  in  1  bus acknowledge

Behaviour:
- SR width W = 2+ADDR_W+DATA_W; shifted LSB first.
- Update frame layout: SR[DATA_W-1:0]=data, next ADDR_W bits=addr, top 2 bits=OP.
- OP encoding: 00 NOP, 01 SETADDR, 10 READ, 11 WRITE.
- Capture layout: data=RDATA_Q (last read), addr=current address register, top bits={ERR,BUSY}.
- RESET: SR=0, REQ=0, WE=0, ADDR=0, WDATA=0, RDATA_Q=0, BUSY=0, ERR=0, state=IDLE.
- RESET overrides everything, including a request in flight; REQ drops on the next edge and ACK is ignored.
- With SEL low, SR holds. A bus transaction already in flight continues independently of SEL.
- SEL&CAPTURE: SR loads the capture word. ERR clears in the same edge (read-to-clear).
  - If an error event occurs on that edge, ERR=1 wins.
- SEL&SHIFT (not CAPTURE): SR={TDI,SR[W-1:1]}. CAPTURE has priority over SHIFT.
- SEL&UPDATE decodes the SR value present before the edge:
  - NOP: no effect.
  - SETADDR: address register=addr field. No bus cycle.
  - READ/WRITE in IDLE: next edge REQ=1, WE=OP[0], WDATA=data field, state=BUSY.
    - The access uses the current address register; the addr field is ignored.
  - Any non-NOP OP while BUSY: ignored, ERR=1. Address and the in-flight access are unchanged.
- State machine IDLE->BUSY on accepted READ/WRITE; BUSY->IDLE on ACK.
  - REQ is registered, so the minimum REQ pulse is 1 cycle.
- ACK sampled high while REQ=1:
  - Next edge REQ=0.
  - If read, RDATA_Q=RDATA.
  - Address register += ADDR_INC, wrapping at 2^ADDR_W.
- ACK while REQ=0 is ignored.
- WE/ADDR/WDATA are held stable throughout REQ.
- BUSY status bit equals REQ.

Optional Feature:
Macro JTAG_BUS_DR_TIMEOUT_EN.
- Enabled:
  - A counter clears when REQ rises and counts while REQ=1 and ACK=0.
  - On reaching TIMEOUT_CYC: REQ=0, ERR=1, state=IDLE. The address register does not increment and RDATA_Q is unchanged.
  - ACK on the same edge as timeout counts as success.
- Disabled: no counter, and REQ waits for ACK indefinitely.

Decomposition:
- Package jtag_bus_dr_pkg holds:
  - OP encodings: OP_NOP, OP_SETADDR, OP_READ, OP_WRITE.
  - Status bit indices ST_BUSY=0, ST_ERR=1.
  - State enum {S_IDLE,S_BUSY}.
- One sub-module is natural: jtag_bus_dr_timer, the timeout counter, instantiated only under the macro.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset then CAPTURE+66 SHIFTs with TDI=0 -> TDO stream all zeros; REQ=0.
- Shift SETADDR addr=0x1000, UPDATE; then WRITE data=0xDEADBEEF, UPDATE -> REQ=1,WE=1,ADDR=0x1000,WDATA=0xDEADBEEF. ACK after 3 cycles -> REQ=0; capture addr=0x1004, BUSY=0.
- READ twice with bus returning 0xBEEF0001 then 0xBEEF0002 -> bus addresses 0x1004,0x1008. Capture after the second read gives data=0xBEEF0002, addr=0x100C.
- WRITE issued, ACK withheld, second WRITE UPDATE -> ignored. Capture shows ERR=1,BUSY=1; next capture ERR=0.
- SETADDR 0xFFFFFFFC, READ, ACK -> address wraps to 0x00000000.
- With macro, TIMEOUT_CYC=8, no ACK -> REQ drops after 8 cycles. Capture ERR=1, address unchanged. Without macro, REQ still high after 1000 cycles.
